// File: rtl/rv32_pkg.sv
// Shared RV32I datapath widths, funct3 encodings and ALU-control helper.
package rv32_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned RIDX_W     = 5;
  localparam int unsigned ALU_CTRL_W = 4;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // I-type ops carry imm[10] in instr[30]; only SRAI/SRLI use it as an ALU select.
  function automatic logic [ALU_CTRL_W-1:0] alu_ctrl(input logic [2:0] funct3,
                                                     input logic       funct7_5,
                                                     input logic       use_imm);
    return {funct3, funct7_5 & ~(use_imm & (funct3 != F3_SR))};
  endfunction

endpackage

// File: rtl/id_ex_stage_operand_fwd.sv
// Hazard compare and operand resolution for one held source register.
// ID_EX_FORWARD_EN selects forwarding muxes; otherwise any producer match stalls.
module operand_fwd #(
  parameter int unsigned XLEN   = rv32_pkg::XLEN,
  parameter int unsigned RIDX_W = rv32_pkg::RIDX_W
) (
  input  logic              uses,
  input  logic [RIDX_W-1:0] rs,
  input  logic [XLEN-1:0]   held_data,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic              mem_is_load,
  input  logic [RIDX_W-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_result,
  input  logic              wb_valid,
  input  logic              wb_reg_write,
  input  logic [RIDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_result,
  output logic              wb_match,
  output logic              stall,
  output logic [XLEN-1:0]   value
);
  import rv32_pkg::*;

  logic active;
  logic mem_match;

  assign active    = uses & (rs != '0);
  assign mem_match = active & mem_valid & mem_reg_write & (mem_rd == rs);
  assign wb_match  = active & wb_valid & wb_reg_write & (wb_rd == rs);

`ifdef ID_EX_FORWARD_EN
  always_comb begin
    stall = mem_match & mem_is_load;
    value = held_data;
    if (mem_match) begin
      value = mem_result;
    end else if (wb_match) begin
      value = wb_result;
    end
  end
`else
  // WB match still stalls: the stored value becomes correct only after the snoop edge.
  logic unused_fwd_data;
  assign unused_fwd_data = ^{mem_is_load, mem_result, wb_result};

  always_comb begin
    stall = mem_match | wb_match;
    value = held_data;
  end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX one-entry pipeline register feeding the RV32I ALU, with RAW hazard resolution.
// Build option: ID_EX_FORWARD_EN enables MEM/WB operand forwarding (load-use stall only).
module id_ex_stage #(
  parameter int unsigned XLEN   = rv32_pkg::XLEN,
  parameter int unsigned RIDX_W = rv32_pkg::RIDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [RIDX_W-1:0] id_rs1,
  input  logic [RIDX_W-1:0] id_rs2,
  input  logic [RIDX_W-1:0] id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_use_pc,
  input  logic              id_use_imm,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7_5,
  input  logic              id_is_load,
  input  logic              id_reg_write,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic              mem_is_load,
  input  logic [RIDX_W-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_result,
  input  logic              wb_valid,
  input  logic              wb_reg_write,
  input  logic [RIDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_result,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   Op1,
  output logic [XLEN-1:0]   Op2,
  output logic [3:0]        Alu_Control,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [XLEN-1:0]   ex_pc,
  output logic [RIDX_W-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_is_load
);
  import rv32_pkg::*;

  logic                  held_valid;
  logic [XLEN-1:0]       h_pc;
  logic [XLEN-1:0]       h_rs1_data;
  logic [XLEN-1:0]       h_rs2_data;
  logic [XLEN-1:0]       h_imm;
  logic [RIDX_W-1:0]     h_rs1;
  logic [RIDX_W-1:0]     h_rs2;
  logic [RIDX_W-1:0]     h_rd;
  logic                  h_uses_rs1;
  logic                  h_uses_rs2;
  logic                  h_use_pc;
  logic                  h_use_imm;
  logic                  h_reg_write;
  logic                  h_is_load;
  logic [ALU_CTRL_W-1:0] h_alu_ctrl;

  logic            wb_match1;
  logic            wb_match2;
  logic            stall1;
  logic            stall2;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            capture;
  logic            consume;

  // rs1 is not an ALU input when Op1 takes the PC, so it cannot cause a hazard then.
  operand_fwd #(.XLEN(XLEN), .RIDX_W(RIDX_W)) u_fwd_rs1 (
    .uses          (h_uses_rs1 & ~h_use_pc),
    .rs            (h_rs1),
    .held_data     (h_rs1_data),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_is_load   (mem_is_load),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .wb_match      (wb_match1),
    .stall         (stall1),
    .value         (rs1_val)
  );

  operand_fwd #(.XLEN(XLEN), .RIDX_W(RIDX_W)) u_fwd_rs2 (
    .uses          (h_uses_rs2),
    .rs            (h_rs2),
    .held_data     (h_rs2_data),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_is_load   (mem_is_load),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .wb_match      (wb_match2),
    .stall         (stall2),
    .value         (rs2_val)
  );

  assign ex_valid = held_valid & ~(stall1 | stall2);
  assign consume  = ex_valid & ex_ready;
  assign id_ready = ~held_valid | consume;
  assign capture  = id_valid & id_ready & ~flush;

  assign Op1           = h_use_pc  ? h_pc  : rs1_val;
  assign Op2           = h_use_imm ? h_imm : rs2_val;
  assign ex_store_data = rs2_val;
  assign Alu_Control   = h_alu_ctrl;
  assign ex_pc         = h_pc;
  assign ex_rd         = h_rd;
  assign ex_reg_write  = h_reg_write;
  assign ex_is_load    = h_is_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      held_valid  <= 1'b0;
      h_pc        <= '0;
      h_rs1_data  <= '0;
      h_rs2_data  <= '0;
      h_imm       <= '0;
      h_rs1       <= '0;
      h_rs2       <= '0;
      h_rd        <= '0;
      h_uses_rs1  <= 1'b0;
      h_uses_rs2  <= 1'b0;
      h_use_pc    <= 1'b0;
      h_use_imm   <= 1'b0;
      h_reg_write <= 1'b0;
      h_is_load   <= 1'b0;
      h_alu_ctrl  <= '0;
    end else if (flush) begin
      held_valid <= 1'b0;
    end else if (capture) begin
      held_valid  <= 1'b1;
      h_pc        <= id_pc;
      h_rs1_data  <= id_rs1_data;
      h_rs2_data  <= id_rs2_data;
      h_imm       <= id_imm;
      h_rs1       <= id_rs1;
      h_rs2       <= id_rs2;
      h_rd        <= id_rd;
      h_uses_rs1  <= id_uses_rs1;
      h_uses_rs2  <= id_uses_rs2;
      h_use_pc    <= id_use_pc;
      h_use_imm   <= id_use_imm;
      h_reg_write <= id_reg_write;
      h_is_load   <= id_is_load;
      h_alu_ctrl  <= alu_ctrl(id_funct3, id_funct7_5, id_use_imm);
    end else if (consume) begin
      held_valid <= 1'b0;
    end else if (held_valid) begin
      // Snoop keeps the stored operands current while the entry waits.
      if (wb_match1) begin
        h_rs1_data <= wb_result;
      end
      if (wb_match2) begin
        h_rs2_data <= wb_result;
      end
    end
  end

endmodule
